spi_bus_xfer: RTL and testbench

- Downstream stage of the SPI bridge. It accepts one pending read or write request (17-bit address, 8-bit data, read/write) through a 4-phase pending/done handshake.
- It waits for the SPI time slot in the free-running bus cycle, then drives the shared RAM bus with a fixed setup/strobe/hold sequence.
- It returns read data and done to the bridge, and tells the top-level bus mux when SPI owns the bus.

---
 rtl/spi_bus_pkg.sv | 16 +
 rtl/bus_slot_counter.sv | 26 ++
 rtl/spi_bus_xfer.sv | 134 +++++++++++++
 tb/tb_spi_bus_xfer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_bus_pkg.sv
// rtl/spi_bus_pkg.sv - shared types for the SPI-side RAM bus transfer stage
package spi_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SETUP,
        STROBE,
        HOLD,
        ACK
    } state_t;

    typedef logic [16:0] addr_t;
    typedef logic [7:0]  data_t;

endpackage

// File: rtl/bus_slot_counter.sv
// rtl/bus_slot_counter.sv - free-running bus-cycle phase counter with slot-start lookahead
module bus_slot_counter #(
    parameter  int CYCLE_LEN = 16,
    parameter  int START     = 8,
    localparam int CW        = $clog2(CYCLE_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] slot_count,
    output logic          start_next
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_count <= '0;
        end else if (slot_count == CW'(CYCLE_LEN - 1)) begin
            slot_count <= '0;
        end else begin
            slot_count <= slot_count + 1'b1;
        end
    end

    // High in the cycle before the slot, so an FSM can enter it on this edge
    assign start_next = (slot_count == CW'(START - 1));

endmodule

// File: rtl/spi_bus_xfer.sv
// rtl/spi_bus_xfer.sv - runs one latched SPI request through the SPI slot of the shared RAM bus
module spi_bus_xfer
    import spi_bus_pkg::*;
#(
    parameter  int CYCLE_LEN      = 16,
    parameter  int SPI_SLOT_START = 8,
    parameter  int STROBE_CYCLES  = 2,
    localparam int CW             = $clog2(CYCLE_LEN)
) (
    input  logic          clk_sys_i,
    input  logic          reset_ni,
    input  logic [16:0]   spi_addr_i,
    input  logic [7:0]    spi_data_i,
    input  logic          spi_rw_ni,
    input  logic          spi_pending_i,
    output logic          spi_done_o,
    output logic [7:0]    spi_data_o,
    output logic          spi_grant_o,
    output logic [16:0]   ram_addr_o,
    output logic [7:0]    ram_data_o,
    output logic          ram_data_oe_o,
    input  logic [7:0]    ram_data_i,
    output logic          ram_ce_no,
    output logic          ram_oe_no,
    output logic          ram_we_no,
    output logic [CW-1:0] slot_count_o
);

    if (SPI_SLOT_START < 1 || SPI_SLOT_START + STROBE_CYCLES + 1 > CYCLE_LEN - 1) begin : g_bad_params
        $fatal(1, "spi_bus_xfer: SPI slot does not fit inside the bus cycle");
    end

    state_t state, state_nxt;
    addr_t  req_addr;
    data_t  req_data;
    logic   req_rw_n;
    logic   aborted;
    logic   start_next;
    logic   strobe_last;
    logic   busy;

    bus_slot_counter #(
        .CYCLE_LEN (CYCLE_LEN),
        .START     (SPI_SLOT_START)
    ) u_slot (
        .clk        (clk_sys_i),
        .rst_n      (reset_ni),
        .slot_count (slot_count_o),
        .start_next (start_next)
    );

    // The counter is never held, so the slot position alone marks the last strobe cycle
    assign strobe_last = (slot_count_o == CW'(SPI_SLOT_START + STROBE_CYCLES));

    always_ff @(posedge clk_sys_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_data   <= '0;
            req_rw_n   <= 1'b1;
            aborted    <= 1'b0;
            spi_data_o <= '0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && spi_pending_i) begin
                req_addr <= spi_addr_i;
                req_data <= spi_data_i;
                req_rw_n <= spi_rw_ni;
            end
            if (state == WAIT) begin
                aborted <= 1'b0;
            end else if (busy && !spi_pending_i) begin
                aborted <= 1'b1;
            end
            if (state_nxt == SETUP) begin
                ram_addr_o <= req_addr;
                if (!req_rw_n) begin
                    ram_data_o <= req_data;
                end
            end
            if (state == STROBE && strobe_last && req_rw_n) begin
                spi_data_o <= ram_data_i;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        spi_grant_o   = 1'b0;
        spi_done_o    = 1'b0;
        ram_ce_no     = 1'b1;
        ram_oe_no     = 1'b1;
        ram_we_no     = 1'b1;
        ram_data_oe_o = 1'b0;
        case (state)
            IDLE: begin
                if (spi_pending_i) state_nxt = WAIT;
            end
            WAIT: begin
                if (!spi_pending_i)  state_nxt = IDLE;
                else if (start_next) state_nxt = SETUP;
            end
            SETUP: begin
                busy      = 1'b1;
                state_nxt = STROBE;
            end
            STROBE: begin
                busy      = 1'b1;
                ram_oe_no = !req_rw_n;
                ram_we_no = req_rw_n;
                if (strobe_last) state_nxt = HOLD;
            end
            HOLD: begin
                busy      = 1'b1;
                // A request withdrawn anywhere in the access still completes but is never acknowledged
                state_nxt = (aborted || !spi_pending_i) ? IDLE : ACK;
            end
            ACK: begin
                spi_done_o = 1'b1;
                if (!spi_pending_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (busy) begin
            spi_grant_o   = 1'b1;
            ram_ce_no     = 1'b0;
            ram_data_oe_o = !req_rw_n;
        end
    end

endmodule

// File: tb/tb_spi_bus_xfer.sv
// tb/tb_spi_bus_xfer.sv - directed self-checking bench for spi_bus_xfer
module tb_spi_bus_xfer;

    logic        clk_sys_i = 1'b0;
    logic        reset_ni;
    logic [16:0] spi_addr_i;
    logic [7:0]  spi_data_i;
    logic        spi_rw_ni;
    logic        spi_pending_i;
    logic        spi_done_o;
    logic [7:0]  spi_data_o;
    logic        spi_grant_o;
    logic [16:0] ram_addr_o;
    logic [7:0]  ram_data_o;
    logic        ram_data_oe_o;
    logic [7:0]  ram_data_i;
    logic        ram_ce_no;
    logic        ram_oe_no;
    logic        ram_we_no;
    logic [3:0]  slot_count_o;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_rdata;

    spi_bus_xfer dut (
        .clk_sys_i     (clk_sys_i),
        .reset_ni      (reset_ni),
        .spi_addr_i    (spi_addr_i),
        .spi_data_i    (spi_data_i),
        .spi_rw_ni     (spi_rw_ni),
        .spi_pending_i (spi_pending_i),
        .spi_done_o    (spi_done_o),
        .spi_data_o    (spi_data_o),
        .spi_grant_o   (spi_grant_o),
        .ram_addr_o    (ram_addr_o),
        .ram_data_o    (ram_data_o),
        .ram_data_oe_o (ram_data_oe_o),
        .ram_data_i    (ram_data_i),
        .ram_ce_no     (ram_ce_no),
        .ram_oe_no     (ram_oe_no),
        .ram_we_no     (ram_we_no),
        .slot_count_o  (slot_count_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_sys_i);
    endtask

    task automatic wait_slot(input int v);
        int n = 0;
        step();
        while (slot_count_o != 4'(v) && n < 40) begin
            step();
            n++;
        end
        check("slot_align", 32'(slot_count_o), 32'(v));
    endtask

    // Request raised at count 3; SETUP 8, STROBE 9-10, HOLD 11, done at 12
    task automatic access(input logic [16:0] a, input logic [7:0] d, input logic rw_n, input logic [7:0] rd);
        wait_slot(3);
        spi_addr_i = a; spi_data_i = d; spi_rw_ni = rw_n; spi_pending_i = 1'b1; ram_data_i = rd;
        step();
        spi_addr_i = ~a; spi_data_i = ~d; spi_rw_ni = ~rw_n;
        wait_slot(8);
        check("setup_grant", spi_grant_o, 1'b1);
        check("setup_ce", ram_ce_no, 1'b0);
        check("setup_addr", ram_addr_o, a);
        check("setup_oe", ram_oe_no, 1'b1);
        check("setup_we", ram_we_no, 1'b1);
        check("setup_data_oe", ram_data_oe_o, !rw_n);
        if (!rw_n) check("setup_wdata", ram_data_o, d);
        for (int i = 0; i < 2; i++) begin
            step();
            check("strobe_oe", ram_oe_no, !rw_n);
            check("strobe_we", ram_we_no, rw_n);
            check("strobe_ce", ram_ce_no, 1'b0);
        end
        step();
        check("hold_oe", ram_oe_no, 1'b1);
        check("hold_we", ram_we_no, 1'b1);
        check("hold_ce", ram_ce_no, 1'b0);
        check("hold_data_oe", ram_data_oe_o, !rw_n);
        step();
        if (rw_n) exp_rdata = rd;
        check("ack_done", spi_done_o, 1'b1);
        check("ack_grant", spi_grant_o, 1'b0);
        check("ack_ce", ram_ce_no, 1'b1);
        check("ack_data_oe", ram_data_oe_o, 1'b0);
        check("ack_addr_kept", ram_addr_o, a);
        check("ack_rdata", spi_data_o, exp_rdata);
        spi_pending_i = 1'b0;
        step();
        check("done_release", spi_done_o, 1'b0);
    endtask

    initial begin
        int lat;
        logic activity;
        reset_ni = 1'b0; spi_addr_i = '0; spi_data_i = '0; spi_rw_ni = 1'b1;
        spi_pending_i = 1'b0; ram_data_i = '0; exp_rdata = 8'h00;
        step(); step();
        check("rst_count", slot_count_o, 4'd0);
        check("rst_done", spi_done_o, 1'b0);
        check("rst_rdata", spi_data_o, 8'h00);
        check("rst_grant", spi_grant_o, 1'b0);
        check("rst_addr", ram_addr_o, 17'h0);
        check("rst_wdata", ram_data_o, 8'h00);
        check("rst_data_oe", ram_data_oe_o, 1'b0);
        check("rst_strobes", {ram_ce_no, ram_oe_no, ram_we_no}, 3'b111);
        reset_ni = 1'b1;

        // 1: read, 2: write
        access(17'h0_1234, 8'h00, 1'b1, 8'h5A);
        access(17'h1_8000, 8'hA5, 1'b0, 8'hEE);

        // 3: late request waits a full bus cycle
        wait_slot(8);
        spi_addr_i = 17'h0_0777; spi_rw_ni = 1'b1; spi_pending_i = 1'b1; ram_data_i = 8'h77;
        activity = 1'b0; lat = 0;
        for (int i = 0; i < 15; i++) begin
            step(); lat++;
            if (!ram_ce_no || spi_grant_o) activity = 1'b1;
        end
        check("late_no_activity", activity, 1'b0);
        step(); lat++;
        check("late_setup_count", slot_count_o, 4'd8);
        check("late_setup_grant", spi_grant_o, 1'b1);
        while (!spi_done_o && lat < 40) begin
            step(); lat++;
        end
        check("late_latency", lat, 20);
        check("late_rdata", spi_data_o, 8'h77);
        exp_rdata = 8'h77;
        spi_pending_i = 1'b0;

        // 4a: withdrawn in WAIT
        wait_slot(3);
        spi_addr_i = 17'h0_0042; spi_rw_ni = 1'b0; spi_data_i = 8'h11; spi_pending_i = 1'b1;
        step();
        spi_pending_i = 1'b0;
        activity = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!ram_ce_no || !ram_oe_no || !ram_we_no || spi_done_o) activity = 1'b1;
        end
        check("wait_withdraw_quiet", activity, 1'b0);

        // 4b: withdrawn at count 9 of a write
        wait_slot(3);
        spi_addr_i = 17'h0_0043; spi_rw_ni = 1'b0; spi_data_i = 8'h22; spi_pending_i = 1'b1;
        wait_slot(9);
        check("wd_we_9", ram_we_no, 1'b0);
        spi_pending_i = 1'b0;
        step();
        check("wd_we_10", ram_we_no, 1'b0);
        step();
        check("wd_hold", {ram_ce_no, ram_we_no}, 2'b01);
        activity = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (spi_done_o || !ram_ce_no) activity = 1'b1;
        end
        check("wd_no_done", activity, 1'b0);

        // 5: reset in the middle of a write strobe
        wait_slot(3);
        spi_addr_i = 17'h0_0044; spi_rw_ni = 1'b0; spi_data_i = 8'h33; spi_pending_i = 1'b1;
        wait_slot(9);
        check("rst5_we_before", ram_we_no, 1'b0);
        #1 reset_ni = 1'b0;
        spi_pending_i = 1'b0;
        #1;
        check("rst5_strobes", {ram_ce_no, ram_oe_no, ram_we_no}, 3'b111);
        check("rst5_count", slot_count_o, 4'd0);
        check("rst5_grant", spi_grant_o, 1'b0);
        step();
        reset_ni = 1'b1;
        exp_rdata = 8'h00;
        activity = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (spi_done_o || !ram_ce_no) activity = 1'b1;
        end
        check("rst5_no_done", activity, 1'b0);

        // 6: back-to-back reads in consecutive bus cycles
        access(17'h0_0010, 8'h00, 1'b1, 8'h3C);
        access(17'h0_0011, 8'h00, 1'b1, 8'hC3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
